// File: rtl/demux_pkg.sv
// Shared types and widths for the nibble-to-word demultiplexer.
package demux_pkg;

    localparam int SLOT_W = 2;
    localparam int LANE_W = 4;
    localparam int WORD_W = 16;
    localparam int GAP_W  = 4;
    localparam int NUM_LANES = 1 << SLOT_W;

    // IDLE: no partial group held; COLLECT: 1..3 nibbles held.
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

endpackage

// File: rtl/gap_counter.sv
// Saturating idle-cycle counter; flags a stalled partial group when the
// count reaches GAP_MAX and rearms itself on the same edge.
module gap_counter
    import demux_pkg::*;
#(
    parameter int GAP_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,   // nibble accepted, or no group open
    input  logic en_i,    // idle cycle inside a partial group
    output logic hit_o,   // this idle cycle is the GAP_MAX-th in a row
    output logic drop_o   // registered one-cycle drop pulse
);

    logic [GAP_W-1:0] cnt_q;
    logic [GAP_W-1:0] cnt_inc;
    logic             drop_q;

    // Saturating increment, so a large GAP_MAX can never wrap back to 0.
    always_comb begin
        cnt_inc = (cnt_q == {GAP_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        hit_o   = en_i && !clr_i && (cnt_inc == GAP_W'(GAP_MAX));
    end

    // Count idle cycles; a hit returns the counter to 0 for the next group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            if (clr_i || hit_o)
                cnt_q <= '0;
            else if (en_i)
                cnt_q <= cnt_inc;
            drop_q <= hit_o;
        end
    end

    assign drop_o = drop_q;

endmodule

// File: rtl/demux14_4b_word.sv
// Round-robin distributor of a valid-qualified nibble stream onto four
// registered lanes, assembling each complete group into a 16-bit word.
module demux14_4b_word
    import demux_pkg::*;
#(
    parameter int GAP_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active low
    input  logic [LANE_W-1:0] in,
    input  logic              in_valid,
    output logic [LANE_W-1:0] out0,
    output logic [LANE_W-1:0] out1,
    output logic [LANE_W-1:0] out2,
    output logic [LANE_W-1:0] out3,
    output logic              out0_valid,
    output logic              out1_valid,
    output logic              out2_valid,
    output logic              out3_valid,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    output logic [SLOT_W-1:0] slot,
    output logic              drop_err
);

    state_e                             state_q, state_d;
    logic [SLOT_W-1:0]                  slot_q, slot_d;
    logic [NUM_LANES-1:0][LANE_W-1:0]   lane_q;
    logic [NUM_LANES-1:0]               lane_vld_q;
    logic [WORD_W-1:0]                  word_q;
    logic                               word_vld_q;

    logic wr_en;
    logic done;
    logic cnt_clr;
    logic cnt_en;
    logic cnt_hit;

    gap_counter #(.GAP_MAX(GAP_MAX)) u_gap (
        .clk    (clk),
        .rst_n  (reset),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .hit_o  (cnt_hit),
        .drop_o (drop_err)
    );

    // Next-state: accept nibbles into slot_q, close the group on slot 3,
    // abandon it when the gap counter hits.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        wr_en   = 1'b0;
        done    = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (in_valid) begin
                    wr_en   = 1'b1;
                    slot_d  = SLOT_W'(1);
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    cnt_clr = 1'b1;
                    if (slot_q == SLOT_W'(NUM_LANES - 1)) begin
                        done    = 1'b1;
                        slot_d  = '0;
                        state_d = IDLE;
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_hit) begin
                        slot_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                slot_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and slot pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    // Lane registers hold stale data across a drop; valids are single pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q     <= '0;
            lane_vld_q <= '0;
        end else begin
            lane_vld_q <= '0;
            if (wr_en) begin
                lane_q[slot_q]     <= in;
                lane_vld_q[slot_q] <= 1'b1;
            end
        end
    end

    // The closing nibble comes straight from the input, not lane 3's register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q     <= '0;
            word_vld_q <= 1'b0;
        end else begin
            word_vld_q <= done;
            if (done)
                word_q <= {in, lane_q[2], lane_q[1], lane_q[0]};
        end
    end

    assign out0       = lane_q[0];
    assign out1       = lane_q[1];
    assign out2       = lane_q[2];
    assign out3       = lane_q[3];
    assign out0_valid = lane_vld_q[0];
    assign out1_valid = lane_vld_q[1];
    assign out2_valid = lane_vld_q[2];
    assign out3_valid = lane_vld_q[3];
    assign word       = word_q;
    assign word_valid = word_vld_q;
    assign slot       = slot_q;

endmodule

// File: tb/tb_demux14_4b_word.sv
// Directed bench for demux14_4b_word with GAP_MAX=4.
module tb_demux14_4b_word;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in;
    logic        in_valid;
    logic [3:0]  out0, out1, out2, out3;
    logic        out0_valid, out1_valid, out2_valid, out3_valid;
    logic [15:0] word;
    logic        word_valid;
    logic [1:0]  slot;
    logic        drop_err;

    int n_cmp = 0;
    int n_mis = 0;

    demux14_4b_word #(.GAP_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .in_valid   (in_valid),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out0_valid (out0_valid),
        .out1_valid (out1_valid),
        .out2_valid (out2_valid),
        .out3_valid (out3_valid),
        .word       (word),
        .word_valid (word_valid),
        .slot       (slot),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    wire [3:0]  vlds  = {out3_valid, out2_valid, out1_valid, out0_valid};
    wire [15:0] lanes = {out3, out2, out1, out0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Apply one input cycle and return 1 time unit after the capturing edge.
    task automatic step(input logic v, input logic [3:0] d);
        in_valid = v;
        in       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 4'hx);
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in       = 4'h0;

        // Reset held 3 cycles, then one idle cycle.
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        idle();
        chk("rst_lanes", lanes, 16'h0000);
        chk("rst_vlds", vlds, 4'b0000);
        chk("rst_word", {word_valid, word}, 17'h0_0000);
        chk("rst_slot_drop", {slot, drop_err}, 3'b000);

        // Single group 1,2,3,4.
        step(1'b1, 4'h1);
        chk("g1_n0", {vlds, out0, slot}, {4'b0001, 4'h1, 2'd1});
        step(1'b1, 4'h2);
        chk("g1_n1", {vlds, out1, slot}, {4'b0010, 4'h2, 2'd2});
        step(1'b1, 4'h3);
        chk("g1_n2", {vlds, out2, slot, word_valid}, {4'b0100, 4'h3, 2'd3, 1'b0});
        step(1'b1, 4'h4);
        chk("g1_n3", {vlds, out3, slot}, {4'b1000, 4'h4, 2'd0});
        chk("g1_word", {word_valid, word}, {1'b1, 16'h4321});
        idle();
        chk("g1_after", {vlds, word_valid, word}, {4'b0000, 1'b0, 16'h4321});

        // Continuous 0..7: words every 4th cycle, no bubbles.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'(i));
            if (i == 3)
                chk("cont_w0", {word_valid, word}, {1'b1, 16'h3210});
            else if (i == 7)
                chk("cont_w1", {word_valid, word}, {1'b1, 16'h7654});
            else
                chk("cont_gap", word_valid, 1'b0);
        end
        idle();
        chk("cont_end", {word_valid, slot}, {1'b0, 2'd0});

        // A,B then 4 idle: drop on the 4th idle edge, slot back to 0.
        step(1'b1, 4'hA);
        step(1'b1, 4'hB);
        chk("drop_slot2", slot, 2'd2);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("drop_wait", {drop_err, slot}, {1'b0, 2'd2});
        end
        idle();
        chk("drop_pulse", {drop_err, slot, word_valid}, {1'b1, 2'd0, 1'b0});
        // Valid while drop_err is high starts a new group at lane 0.
        step(1'b1, 4'h5);
        chk("drop_single", drop_err, 1'b0);
        chk("drop_new0", {vlds, out0, slot}, {4'b0001, 4'h5, 2'd1});
        chk("drop_word_held", word, 16'h7654);
        step(1'b1, 4'h6);
        step(1'b1, 4'h7);
        chk("drop_word_held2", {word_valid, word}, {1'b0, 16'h7654});
        step(1'b1, 4'h8);
        chk("drop_word_new", {word_valid, word}, {1'b1, 16'h8765});

        // A,B, 3 idle (below GAP_MAX), C,D: group survives.
        idle();
        step(1'b1, 4'hA);
        step(1'b1, 4'hB);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("gap3_nodrop", drop_err, 1'b0);
        end
        step(1'b1, 4'hC);
        chk("gap3_c", {drop_err, out2, slot}, {1'b0, 4'hC, 2'd3});
        step(1'b1, 4'hD);
        chk("gap3_word", {word_valid, word, drop_err}, {1'b1, 16'hDCBA, 1'b0});

        // Asynchronous reset mid-group clears everything before the next edge.
        idle();
        step(1'b1, 4'h1);
        step(1'b1, 4'h2);
        #2 reset = 1'b0;
        #1;
        chk("arst_lanes", lanes, 16'h0000);
        chk("arst_misc", {vlds, word_valid, word, slot, drop_err}, 27'h0);
        @(posedge clk);
        #1;
        chk("arst_hold", {drop_err, slot}, 3'b000);
        reset = 1'b1;
        step(1'b1, 4'h9);
        chk("arst_n0", {vlds, out0, slot}, {4'b0001, 4'h9, 2'd1});
        step(1'b1, 4'hA);
        step(1'b1, 4'hB);
        step(1'b1, 4'hC);
        chk("arst_word", {word_valid, word, drop_err}, {1'b1, 16'hCBA9, 1'b0});
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got stalled want finish");
        $fatal(1);
    end

endmodule
